mod_fixed_mul_sched: RTL and testbench

- Round-robin scheduler that time-shares one fixed-point multiplier among NUM_REQ requesters (e.g. synth voices, envelope and gain stages).
- Each requester presents an operand pair with a valid/ready handshake.
- The block arbitrates, registers operands, multiplies, registers the result, and returns it tagged to the originating requester.
- Fully pipelined: one accepted request per cycle, fixed 2-cycle latency.

---
 rtl/mod_fixed_mul_sched_pkg.sv | 18 +
 rtl/mod_fixed_mul_sched_if.sv | 23 ++
 rtl/mod_fixed_mul.sv | 13 +
 rtl/mod_rr_arbiter.sv | 57 +++++
 rtl/mod_fixed_mul_sched.sv | 94 +++++++++
 tb/tb_mod_fixed_mul_sched.sv | 197 +++++++++++++++++++
 6 files changed

// File: rtl/mod_fixed_mul_sched_pkg.sv
// Shared types and constants for the round-robin fixed-point multiplier scheduler.
package mod_fixed_mul_sched_pkg;

  localparam int unsigned NumReqDef     = 4;
  localparam int unsigned InputWidthDef = 32;
  localparam int unsigned InputPointDef = 8;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int unsigned req_id_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned REQ_ID_W = req_id_w(NumReqDef);

  typedef logic [InputWidthDef-1:0] fixed_t;
  typedef logic [REQ_ID_W-1:0]      req_id_t;

endpackage

// File: rtl/mod_fixed_mul_sched_if.sv
// Request/response bundle between requesters and the multiplier scheduler.
interface mod_fixed_mul_sched_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned INPUT_WIDTH = 32
);
  logic [NUM_REQ-1:0]                  i_req_valid;
  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] i_req_a;
  logic [NUM_REQ-1:0][INPUT_WIDTH-1:0] i_req_b;
  logic [NUM_REQ-1:0]                  o_req_ready;
  logic [NUM_REQ-1:0]                  o_rsp_valid;
  logic [INPUT_WIDTH-1:0]              o_rsp_data;
  logic                                o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_busy
  );
endinterface

// File: rtl/mod_fixed_mul.sv
// Unsigned fixed-point multiply: full-width product, shift out fraction, keep low word.
module mod_fixed_mul #(
  parameter int unsigned INPUT_WIDTH = 32,
  parameter int unsigned INPUT_POINT = 8
) (
  input  logic [INPUT_WIDTH-1:0] a_i,
  input  logic [INPUT_WIDTH-1:0] b_i,
  output logic [INPUT_WIDTH-1:0] p_o
);

  assign p_o = INPUT_WIDTH'(((2 * INPUT_WIDTH)'(a_i) * (2 * INPUT_WIDTH)'(b_i)) >> INPUT_POINT);

endmodule

// File: rtl/mod_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus binary index, with the rotating pointer register.
module mod_rr_arbiter
  import mod_fixed_mul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW    = req_id_w(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdW-1:0]     idx_o,
  output logic               valid_o
);

  logic [IdW-1:0]     ptr_q, ptr_d;
  logic [IdW-1:0]     cand;
  logic [IdW-1:0]     idx;
  logic [NUM_REQ-1:0] gnt;
  logic               found;

  // Scan starting at the pointer; first valid requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdW'((32'(ptr_q) + off) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (idx == IdW'(NUM_REQ - 1)) ? '0 : idx + IdW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o   = gnt;
  assign idx_o   = idx;
  assign valid_o = found;

endmodule

// File: rtl/mod_fixed_mul_sched.sv
// Time-shares one fixed-point multiplier among NUM_REQ requesters with a 2-stage pipeline.
module mod_fixed_mul_sched
  import mod_fixed_mul_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = NumReqDef,
  parameter int unsigned INPUT_WIDTH = InputWidthDef,
  parameter int unsigned INPUT_POINT = InputPointDef,
  localparam int unsigned IdW        = req_id_w(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  mod_fixed_mul_sched_if.slave  bus
);

  logic [NUM_REQ-1:0]     gnt;
  logic [IdW-1:0]         win_idx;
  logic                   accept;
  logic [INPUT_WIDTH-1:0] mul_p;
  logic [NUM_REQ-1:0]     rsp_valid;

  logic [INPUT_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s2_data_q, s2_data_d;
  logic [IdW-1:0]         s1_id_q, s1_id_d, s2_id_q, s2_id_d;
  logic                   s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;

  mod_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .req_i   (bus.i_req_valid),
    .gnt_o   (gnt),
    .idx_o   (win_idx),
    .valid_o (accept)
  );

  mod_fixed_mul #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .INPUT_POINT (INPUT_POINT)
  ) u_mul (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (mul_p)
  );

  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_id_d    = s1_id_q;
    if (accept) begin
      s1_a_d  = bus.i_req_a[win_idx];
      s1_b_d  = bus.i_req_b[win_idx];
      s1_id_d = win_idx;
    end
    s2_valid_d = s1_valid_q;
    s2_id_d    = s1_id_q;
    // Result bus keeps its last value across idle cycles.
    s2_data_d  = s1_valid_q ? mul_p : s2_data_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_id_q    <= s2_id_d;
      s2_data_q  <= s2_data_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = s2_valid_q && (s2_id_q == IdW'(i));
    end
  end

  // Grants are suppressed while reset is held so nothing looks accepted.
  assign bus.o_req_ready = i_rst_n ? gnt : '0;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = s2_data_q;
  assign bus.o_busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_mod_fixed_mul_sched.sv
// Directed bench for the round-robin fixed-point multiplier scheduler.
module tb_mod_fixed_mul_sched;
  import mod_fixed_mul_sched_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mod_fixed_mul_sched_if #(.NUM_REQ(N), .INPUT_WIDTH(W)) bus ();

  mod_fixed_mul_sched #(
    .NUM_REQ     (N),
    .INPUT_WIDTH (W),
    .INPUT_POINT (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    fixed_t exp_d;
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.i_req_valid = '0;
    for (int i = 0; i < N; i++) begin
      bus.i_req_a[i] = '0;
      bus.i_req_b[i] = '0;
    end

    // Reset state, with every requester asserting valid.
    step();
    bus.i_req_valid = 4'b1111;
    #1;
    check("rst_ready", 64'(bus.o_req_ready), 64'h0);
    check("rst_busy", 64'(bus.o_busy), 64'h0);
    check("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    check("rst_rsp_data", 64'(bus.o_rsp_data), 64'h0);
    bus.i_req_valid = '0;

    // Single request: 1.5 * 2.0 = 3.0.
    step();
    rst_n = 1'b1;
    step();
    bus.i_req_valid = 4'b0001;
    bus.i_req_a[0]  = 32'h180;
    bus.i_req_b[0]  = 32'h200;
    #1;
    check("single_ready", 64'(bus.o_req_ready), 64'h1);
    step();
    bus.i_req_valid = '0;
    #1;
    check("single_s1_busy", 64'(bus.o_busy), 64'h1);
    check("single_s1_rsp", 64'(bus.o_rsp_valid), 64'h0);
    step();
    #1;
    check("single_rsp_valid", 64'(bus.o_rsp_valid), 64'h1);
    check("single_rsp_data", 64'(bus.o_rsp_data), 64'h300);
    step();
    #1;
    check("single_after_valid", 64'(bus.o_rsp_valid), 64'h0);
    check("single_data_hold", 64'(bus.o_rsp_data), 64'h300);
    check("single_idle_busy", 64'(bus.o_busy), 64'h0);

    // All four valid from reset: grants 0,1,2,3,0,1 and in-order responses.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.i_req_a[i] = 32'((i + 1) << 8);
      bus.i_req_b[i] = 32'h200;
    end
    for (int c = 0; c < 8; c++) begin
      step();
      bus.i_req_valid = (c < 6) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 6) check($sformatf("rr_grant_%0d", c), 64'(bus.o_req_ready), 64'(1 << (c % 4)));
      if (c >= 2) begin
        check($sformatf("rr_rsp_valid_%0d", c), 64'(bus.o_rsp_valid),
              64'(1 << ((c - 2) % 4)));
        check($sformatf("rr_rsp_data_%0d", c), 64'(bus.o_rsp_data),
              64'((((c - 2) % 4) + 1) << 9));
      end
    end

    // Pointer now 2; only 0 and 3 valid -> 3 then 0. Also truncation vectors.
    step();
    bus.i_req_a[3] = 32'hFFFF_FFFF;
    bus.i_req_b[3] = 32'h0000_0200;
    bus.i_req_a[0] = 32'h1;
    bus.i_req_b[0] = 32'h1;
    bus.i_req_valid = 4'b1001;
    #1;
    check("wrap_grant3", 64'(bus.o_req_ready), 64'h8);
    step();
    #1;
    check("wrap_grant0", 64'(bus.o_req_ready), 64'h1);
    step();
    bus.i_req_valid = '0;
    #1;
    check("trunc_rsp_valid3", 64'(bus.o_rsp_valid), 64'h8);
    exp_d = 32'hFFFF_FFFE;
    check("trunc_rsp_data3", 64'(bus.o_rsp_data), 64'(exp_d));
    step();
    bus.i_req_valid = 4'b0101;
    #1;
    check("trunc_rsp_valid0", 64'(bus.o_rsp_valid), 64'h1);
    check("trunc_rsp_data0", 64'(bus.o_rsp_data), 64'h0);
    check("ptr_is_1_grant2", 64'(bus.o_req_ready), 64'h4);
    step();
    bus.i_req_valid = '0;
    #1;
    check("gap_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    step();
    #1;
    check("req2_rsp_valid", 64'(bus.o_rsp_valid), 64'h4);
    check("req2_rsp_data", 64'(bus.o_rsp_data), 64'h600);

    // Two accepts (ptr=3 -> req0, then req1), then reset discards them.
    step();
    bus.i_req_valid = 4'b0011;
    #1;
    check("mid_grant0", 64'(bus.o_req_ready), 64'h1);
    step();
    #1;
    check("mid_grant1", 64'(bus.o_req_ready), 64'h2);
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(bus.o_req_ready), 64'h0);
    check("mid_rst_busy", 64'(bus.o_busy), 64'h0);
    check("mid_rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h0);
    check("mid_rst_rsp_data", 64'(bus.o_rsp_data), 64'h0);
    step();
    #1;
    check("mid_rst_rsp_valid2", 64'(bus.o_rsp_valid), 64'h0);
    step();
    rst_n = 1'b1;
    bus.i_req_valid = 4'b0110;
    #1;
    check("post_rst_grant1", 64'(bus.o_req_ready), 64'h2);
    step();
    bus.i_req_valid = '0;
    #1;
    check("post_rst_no_rsp", 64'(bus.o_rsp_valid), 64'h0);
    step();
    #1;
    check("post_rst_rsp_valid", 64'(bus.o_rsp_valid), 64'h2);
    check("post_rst_rsp_data", 64'(bus.o_rsp_data), 64'h400);

    // ptr=2: grant req2 alone, then req2 loses to req1 for one cycle and drops valid.
    step();
    bus.i_req_valid = 4'b0100;
    #1;
    check("drop_pre_grant2", 64'(bus.o_req_ready), 64'h4);
    step();
    bus.i_req_valid = 4'b0110;
    #1;
    check("drop_grant1", 64'(bus.o_req_ready), 64'h2);
    step();
    bus.i_req_valid = '0;
    #1;
    check("drop_rsp2", 64'(bus.o_rsp_valid), 64'h4);
    step();
    #1;
    check("drop_rsp1", 64'(bus.o_rsp_valid), 64'h2);
    check("drop_rsp1_data", 64'(bus.o_rsp_data), 64'h400);
    step();
    #1;
    check("drop_no_rsp2", 64'(bus.o_rsp_valid), 64'h0);
    check("drop_idle_busy", 64'(bus.o_busy), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
